// File: rtl/seven_seg_pkg.sv
// Shared constants for the seven-segment receive path: active-low segment
// patterns in {a,b,c,d,e,f,g} order, FSM state codes and anode helpers.
package seven_seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETTLE = 2'd1;
    localparam logic [1:0] HELD   = 2'd2;

    // Position of the (single) low anode bit; only meaningful when one-hot-low.
    function automatic logic [1:0] onehot_low_index(input logic [3:0] an);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!an[i]) idx = 2'(i);
        end
        return idx;
    endfunction

    function automatic logic is_onehot_low(input logic [3:0] an);
        return $countones(~an) == 1;
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// Combinational lookup from an active-low segment pattern to a BCD digit,
// flagging legal digits and the all-off blank pattern.
module seg7_to_bcd
    import seven_seg_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] digit,
    output logic       legal,
    output logic       blank
);

    always_comb begin
        digit = 4'hF;
        legal = 1'b1;
        case (seg)
            SEG_0:   digit = 4'd0;
            SEG_1:   digit = 4'd1;
            SEG_2:   digit = 4'd2;
            SEG_3:   digit = 4'd3;
            SEG_4:   digit = 4'd4;
            SEG_5:   digit = 4'd5;
            SEG_6:   digit = 4'd6;
            SEG_7:   digit = 4'd7;
            SEG_8:   digit = 4'd8;
            SEG_9:   digit = 4'd9;
            default: legal = 1'b0;
        endcase
    end

    assign blank = (seg == SEG_BLANK);

endmodule

// File: rtl/seven_segment_decoder.sv
// Display monitor: synchronises the multiplexed anode/cathode pins, waits for
// each digit slot to settle, then publishes per-slot BCD, flags and a 0-99 value.
module seven_segment_decoder
    import seven_seg_pkg::*;
#(
    parameter int         SETTLE_CYCLES  = 16,
    parameter int         TIMEOUT_CYCLES = 200000,
    parameter logic [3:0] DIGIT_MASK     = 4'b1100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  anode,
    input  logic [6:0]  cathode,
    output logic [15:0] bcd,
    output logic [3:0]  digit_valid,
    output logic [3:0]  digit_err,
    output logic [6:0]  value,
    output logic        update,
    output logic        frame_done,
    output logic        stale
);

    localparam int            TW          = $clog2(TIMEOUT_CYCLES);
    localparam logic [15:0]   SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0]   SETTLE_CAP  = 16'(SETTLE_CYCLES - 2);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TO_HIT      = TW'(TIMEOUT_CYCLES - 2);

    logic [3:0]    anode_s1, anode_sync;
    logic [6:0]    cathode_s1, cathode_sync;
    logic [10:0]   pins_prev;
    logic [15:0]   stable_cnt;
    logic [TW-1:0] timeout_cnt;
    logic [1:0]    state, state_next;
    logic [3:0]    seen, seen_with;
    logic [1:0]    slot;
    logic          changed, onehot, capture, timeout_hit;
    logic [3:0]    dec_digit;
    logic          dec_legal, dec_blank;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            anode_s1     <= '1;
            anode_sync   <= '1;
            cathode_s1   <= '1;
            cathode_sync <= '1;
            pins_prev    <= '1;
        end else begin
            anode_s1     <= anode;
            anode_sync   <= anode_s1;
            cathode_s1   <= cathode;
            cathode_sync <= cathode_s1;
            pins_prev    <= {anode_sync, cathode_sync};
        end
    end

    assign changed   = ({anode_sync, cathode_sync} != pins_prev);
    assign onehot    = is_onehot_low(anode_sync);
    assign slot      = onehot_low_index(anode_sync);
    assign seen_with = seen | (4'b0001 << slot);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stable_cnt <= '0;
        end else if (changed) begin
            stable_cnt <= '0;
        end else if (stable_cnt != SETTLE_LAST) begin
            stable_cnt <= stable_cnt + 16'd1;
        end
    end

    // Capture fires on the edge where the stable count reaches SETTLE_CYCLES-1.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (onehot) state_next = SETTLE;
            end
            SETTLE: begin
                if (!onehot) begin
                    state_next = IDLE;
                end else if (!changed && stable_cnt == SETTLE_CAP) begin
                    capture    = 1'b1;
                    state_next = HELD;
                end
            end
            HELD: begin
                if (changed) state_next = onehot ? SETTLE : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    assign timeout_hit = !capture && (timeout_cnt >= TO_HIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timeout_cnt <= '0;
        end else if (capture) begin
            timeout_cnt <= '0;
        end else if (timeout_cnt != TO_LAST) begin
            timeout_cnt <= timeout_cnt + 1'b1;
        end
    end

    seg7_to_bcd u_seg7_to_bcd (
        .seg   (cathode_sync),
        .digit (dec_digit),
        .legal (dec_legal),
        .blank (dec_blank)
    );

    // A completing capture clears the seen set outright, so it never seeds the next frame.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bcd         <= 16'hFFFF;
            digit_valid <= '0;
            digit_err   <= '0;
            update      <= 1'b0;
            frame_done  <= 1'b0;
            stale       <= 1'b1;
            seen        <= '0;
        end else begin
            update     <= capture;
            frame_done <= 1'b0;
            if (capture) begin
                bcd[{slot, 2'b00} +: 4] <= dec_legal ? dec_digit : 4'hF;
                digit_valid[slot]       <= dec_legal;
                digit_err[slot]         <= !dec_legal && !dec_blank;
                stale                   <= 1'b0;
                if ((seen_with & DIGIT_MASK) == DIGIT_MASK) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen_with;
                end
            end else if (timeout_hit) begin
                bcd         <= 16'hFFFF;
                digit_valid <= '0;
                stale       <= 1'b1;
                seen        <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            value <= '0;
        end else if (digit_valid[3] && digit_valid[2]) begin
            value <= {3'b000, bcd[15:12]} * 7'd10 + {3'b000, bcd[11:8]};
        end else begin
            value <= '0;
        end
    end

endmodule
